panda_shift_sequencer: RTL and testbench

Sequencing and arbitration front-end for the core's single barrel shifter (`panda_shifter`). It lets `NumReq` requesters share one shifter through valid/ready handshakes, with round-robin arbitration. It executes plain shifts in one shifter pass and rotates in two passes, returning a tagged result on a response channel. It sits between the issue logic (ALU, bit-manip unit) and the shifter datapath.

---
 rtl/panda_pkg.sv | 29 ++
 rtl/panda_shifter.sv | 23 ++
 rtl/panda_shift_sequencer.sv | 149 ++++++++++++++
 tb/tb_panda_shift_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared types for the shift sequencer: operation encoding, FSM states, op helpers.
package panda_pkg;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } shift_seq_state_e;

  // Rotates need a second, opposite-direction pass.
  function automatic logic is_rotate(logic [2:0] op);
    return (op == ROL) || (op == ROR);
  endfunction

  // Encodings above ROR are reserved and produce a zero result.
  function automatic logic is_valid_op(logic [2:0] op);
    return op <= ROR;
  endfunction

endpackage

// File: rtl/panda_shifter.sv
// Combinational barrel shifter: left logical, right logical or right arithmetic.
module panda_shifter #(
  parameter int unsigned Width       = 32,
  parameter int unsigned AmountWidth = $clog2(Width)
) (
  input  logic [Width-1:0]       operand_i,
  input  logic [AmountWidth-1:0] amount_i,
  input  logic                   left_i,
  input  logic                   arithmetic_i,
  output logic [Width-1:0]       result_o
);

  // Direction and fill select; arithmetic only applies to right shifts.
  always_comb begin
    result_o = operand_i >> amount_i;
    if (left_i) begin
      result_o = operand_i << amount_i;
    end else if (arithmetic_i) begin
      result_o = $signed(operand_i) >>> amount_i;
    end
  end

endmodule

// File: rtl/panda_shift_sequencer.sv
// Round-robin front-end sharing one barrel shifter; rotates take two passes.
module panda_shift_sequencer
  import panda_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned AmountWidth = $clog2(Width),
  parameter int unsigned NumReq      = 2,
  parameter int unsigned IdWidth     = $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][2:0]              req_op_i,
  input  logic [NumReq-1:0][Width-1:0]        req_operand_i,
  input  logic [NumReq-1:0][AmountWidth-1:0]  req_amount_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [IdWidth-1:0]                  rsp_id_o,
  output logic [Width-1:0]                    rsp_result_o
);

  shift_seq_state_e       state_q;
  logic [IdWidth-1:0]     rr_ptr_q;
  logic [2:0]             op_q;
  logic [Width-1:0]       operand_q;
  logic [AmountWidth-1:0] amount_q;
  logic [IdWidth-1:0]     id_q;
  logic [Width-1:0]       partial_q;
  logic                   rsp_valid_q;
  logic [IdWidth-1:0]     rsp_id_q;
  logic [Width-1:0]       rsp_result_q;

  logic                   grant_found;
  logic [IdWidth-1:0]     grant_id;
  logic [IdWidth-1:0]     rr_ptr_d;
  logic                   sh_left;
  logic                   sh_arith;
  logic [AmountWidth-1:0] sh_amount;
  logic [Width-1:0]       sh_result;
  logic [Width-1:0]       partial_d;

  // Round-robin pick: first valid requester at or after rr_ptr.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(rr_ptr_q) + i) % NumReq;
      if (!grant_found && req_valid_i[IdWidth'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = IdWidth'(idx);
      end
    end
    rr_ptr_d = IdWidth'((32'(grant_id) + 1) % NumReq);
  end

  // Ready is offered only in IDLE and only to the arbitration winner.
  always_comb begin
    req_ready_o = '0;
    if ((state_q == IDLE) && grant_found) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  // Shifter control: op-directed first pass, opposite-direction logical second pass.
  always_comb begin
    sh_left   = (op_q == SLL) || (op_q == ROL);
    sh_arith  = (op_q == SRA);
    sh_amount = amount_q;
    if (state_q == PASS2) begin
      sh_left   = (op_q == ROR);
      sh_arith  = 1'b0;
      sh_amount = '0 - amount_q;
    end
  end

  panda_shifter #(
    .Width       (Width),
    .AmountWidth (AmountWidth)
  ) u_shifter (
    .operand_i    (operand_q),
    .amount_i     (sh_amount),
    .left_i       (sh_left),
    .arithmetic_i (sh_arith),
    .result_o     (sh_result)
  );

  assign partial_d = is_valid_op(op_q) ? sh_result : '0;

  // Sequencer FSM with registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_q         <= '0;
      operand_q    <= '0;
      amount_q     <= '0;
      id_q         <= '0;
      partial_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            op_q      <= req_op_i[grant_id];
            operand_q <= req_operand_i[grant_id];
            amount_q  <= req_amount_i[grant_id];
            id_q      <= grant_id;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= PASS1;
          end
        end
        PASS1: begin
          partial_q <= partial_d;
          if (is_rotate(op_q) && (amount_q != '0)) begin
            state_q <= PASS2;
          end else begin
            rsp_result_q <= partial_d;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        PASS2: begin
          rsp_result_q <= partial_q | sh_result;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;

endmodule

// File: tb/tb_panda_shift_sequencer.sv
// Directed bench for panda_shift_sequencer at Width=32, NumReq=2.
module tb_panda_shift_sequencer;

  logic             clk;
  logic             rst_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][2:0]  req_op_i;
  logic [1:0][31:0] req_operand_i;
  logic [1:0][4:0]  req_amount_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_id_o;
  logic [31:0]      rsp_result_o;

  int total = 0;
  int bad   = 0;

  panda_shift_sequencer #(.Width(32), .NumReq(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_operand_i (req_operand_i),
    .req_amount_i  (req_amount_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_id_o      (rsp_id_o),
    .rsp_result_o  (rsp_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and wait (bounded) for its handshake edge.
  task automatic send(input int r, input logic [2:0] op, input logic [31:0] opnd,
                      input logic [4:0] amt, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_op_i[r]      = op;
    req_operand_i[r] = opnd;
    req_amount_i[r]  = amt;
    req_valid_i[r]   = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (req_ready_o[r]) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    req_valid_i[r] = 1'b0;
  endtask

  // Cycles from accept cycle N until rsp_valid_o is seen; -1 on timeout.
  task automatic wait_rsp(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 1;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid_o) seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  // Full transaction with the consumer always ready.
  task automatic run_op(input int r, input logic [2:0] op, input logic [31:0] opnd,
                        input logic [4:0] amt, output int lat, output logic id,
                        output logic [31:0] res);
    bit ok;
    rsp_ready_i = 1'b1;
    lat = -1;
    id  = 1'bx;
    res = 32'hDEAD_BEEF;
    send(r, op, opnd, amt, ok);
    if (ok) begin
      wait_rsp(lat);
      id  = rsp_id_o;
      res = rsp_result_o;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    req_op_i = '0;
    req_operand_i = '0;
    req_amount_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid_o); end
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
    total++; if (rsp_id_o !== 1'b0) begin bad++; $display("FAIL reset_id: got %b want 0", rsp_id_o); end
    total++; if (rsp_result_o !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", rsp_result_o); end
  endtask

  task automatic test_sra();
    int lat; logic id; logic [31:0] res;
    run_op(0, 3'd2, 32'h8000_0000, 5'd4, lat, id, res);
    total++; if (lat !== 2) begin bad++; $display("FAIL sra_latency: got %0d want 2", lat); end
    total++; if (id !== 1'b0) begin bad++; $display("FAIL sra_id: got %b want 0", id); end
    total++; if (res !== 32'hF800_0000) begin bad++; $display("FAIL sra_result: got %h want f8000000", res); end
  endtask

  task automatic test_rotate();
    int          req  [3] = '{1, 0, 1};
    logic [2:0]  op   [3] = '{3'd3, 3'd4, 3'd4};
    logic [31:0] opnd [3] = '{32'h8000_0001, 32'h8000_0001, 32'h1234_5678};
    logic [4:0]  amt  [3] = '{5'd1, 5'd4, 5'd0};
    logic [31:0] exp  [3] = '{32'h0000_0003, 32'h1800_0000, 32'h1234_5678};
    int          elat [3] = '{3, 3, 2};
    int lat; logic id; logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      run_op(req[i], op[i], opnd[i], amt[i], lat, id, res);
      total++; if (lat !== elat[i]) begin bad++; $display("FAIL rot%0d_latency: got %0d want %0d", i, lat, elat[i]); end
      total++; if (id !== req[i][0]) begin bad++; $display("FAIL rot%0d_id: got %b want %0d", i, id, req[i]); end
      total++; if (res !== exp[i]) begin bad++; $display("FAIL rot%0d_result: got %h want %h", i, res, exp[i]); end
    end
  endtask

  task automatic test_other_ops();
    int lat; logic id; logic [31:0] res;
    run_op(0, 3'd5, 32'hFFFF_FFFF, 5'd3, lat, id, res);
    total++; if (lat !== 2) begin bad++; $display("FAIL badop_latency: got %0d want 2", lat); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL badop_result: got %h want 0", res); end
    run_op(1, 3'd0, 32'h0000_0003, 5'd31, lat, id, res);
    total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL sll31_result: got %h want 80000000", res); end
    total++; if (id !== 1'b1) begin bad++; $display("FAIL sll31_id: got %b want 1", id); end
  endtask

  task automatic test_arbitration();
    int          grants  [4] = '{-1, -1, -1, -1};
    int          ids     [4] = '{-1, -1, -1, -1};
    logic [31:0] results [4] = '{32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
    int ng = 0;
    int nr = 0;
    logic [31:0] want;
    @(negedge clk);
    rsp_ready_i      = 1'b1;
    req_op_i         = {3'd0, 3'd0};
    req_operand_i    = {32'h1, 32'h1};
    req_amount_i     = {5'd1, 5'd0};
    req_valid_i      = 2'b11;
    for (int t = 0; t < 60 && nr < 4; t++) begin
      #1;
      if (req_ready_o != 2'b00 && ng < 4) begin
        total++; if (req_ready_o !== 2'b01 && req_ready_o !== 2'b10) begin bad++; $display("FAIL arb_onehot: got %b want one-hot", req_ready_o); end
        grants[ng] = req_ready_o[1] ? 1 : 0;
        ng++;
      end
      if (rsp_valid_o && nr < 4) begin
        ids[nr]     = int'(rsp_id_o);
        results[nr] = rsp_result_o;
        nr++;
      end
      @(negedge clk);
    end
    req_valid_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 1) ? 32'h2 : 32'h1;
      total++; if (grants[i] !== i % 2) begin bad++; $display("FAIL arb_grant%0d: got %0d want %0d", i, grants[i], i % 2); end
      total++; if (ids[i] !== i % 2) begin bad++; $display("FAIL arb_id%0d: got %0d want %0d", i, ids[i], i % 2); end
      total++; if (results[i] !== want) begin bad++; $display("FAIL arb_result%0d: got %h want %h", i, results[i], want); end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    rsp_ready_i = 1'b0;
    send(0, 3'd1, 32'hF000_000F, 5'd8, ok);
    wait_rsp(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", lat); end
    @(negedge clk);
    req_op_i[1]      = 3'd0;
    req_operand_i[1] = 32'h1;
    req_amount_i[1]  = 5'd4;
    req_valid_i[1]   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", c, rsp_valid_o); end
      total++; if (rsp_result_o !== 32'h00F0_0000) begin bad++; $display("FAIL bp_result%0d: got %h want 00f00000", c, rsp_result_o); end
      total++; if (rsp_id_o !== 1'b0) begin bad++; $display("FAIL bp_id%0d: got %b want 0", c, rsp_id_o); end
      total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL bp_ready%0d: got %b want 00", c, req_ready_o); end
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL bp_handshake: got %b want 0", rsp_valid_o); end
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL bp_next_ready: got %b want 10", req_ready_o); end
    @(posedge clk);
    #1;
    req_valid_i[1] = 1'b0;
    wait_rsp(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL bp2_latency: got %0d want 2", lat); end
    total++; if (rsp_result_o !== 32'h0000_0010) begin bad++; $display("FAIL bp2_result: got %h want 00000010", rsp_result_o); end
    total++; if (rsp_id_o !== 1'b1) begin bad++; $display("FAIL bp2_id: got %b want 1", rsp_id_o); end
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; int seen;
    // Reset while a response is being held: outputs clear without a clock edge.
    rsp_ready_i = 1'b0;
    send(0, 3'd0, 32'h1, 5'd1, ok);
    wait_rsp(lat);
    #2;
    rst_i = 1'b1;
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", rsp_valid_o); end
    total++; if (rsp_result_o !== 32'h0) begin bad++; $display("FAIL rst_resp_result: got %h want 0", rsp_result_o); end
    @(negedge clk);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    // Reset during PASS2 of a rotate: the op is dropped.
    send(0, 3'd3, 32'h8000_0001, 5'd1, ok);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_pass2_valid: got %b want 0", rsp_valid_o); end
    @(negedge clk);
    rst_i = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_response: got %0d responses want 0", seen); end
    @(negedge clk);
    req_op_i      = {3'd0, 3'd0};
    req_operand_i = {32'h1, 32'h1};
    req_amount_i  = {5'd0, 5'd0};
    req_valid_i   = 2'b11;
    #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL rst_first_grant: got %b want 01", req_ready_o); end
    req_valid_i = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sra();
    test_rotate();
    test_other_ops();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
